// File: rtl/trap_controller.sv
// trap_controller: arbitrates fetch/execute exception codes, commits traps
// (mepc/mcause/mtval, privilege switch), executes mret, and drives the
// PC-redirect and F/D/E flush pulses. A trap taken while already in the
// handler locks the core up until reset.
module trap_controller #(
  parameter int XLEN = 2  // XLEN_64b; data width W = 1 << (XLEN + 4)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [3:0]                  i_exception_code_f,
  input  logic [(1 << (XLEN+4))-1:0]  i_pc_f,
  input  logic                        i_valid_e,
  input  logic [3:0]                  i_exception_code_e,
  input  logic [(1 << (XLEN+4))-1:0]  i_pc_e,
  input  logic [(1 << (XLEN+4))-1:0]  i_alu_out_e,
  input  logic                        i_mret_e,
  input  logic                        i_branch_taken_e,
  input  logic [(1 << (XLEN+4))-1:0]  i_mtvec,
  output logic                        o_redirect_en,
  output logic [(1 << (XLEN+4))-1:0]  o_redirect_pc,
  output logic                        o_flush_fde,
  output logic [1:0]                  o_current_privilege,
  output logic [(1 << (XLEN+4))-1:0]  o_mepc,
  output logic [(1 << (XLEN+4))-1:0]  o_mcause,
  output logic [(1 << (XLEN+4))-1:0]  o_mtval,
  output logic                        o_in_trap,
  output logic                        o_halt
);

  localparam int W = 1 << (XLEN + 4);

  // Exception codes shared with the exception signal handler.
  localparam logic [3:0] E_INSTR_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT            = 4'd3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] E_STORE_ADDR_FAULT      = 4'd7;
  localparam logic [3:0] E_ECALL                 = 4'd8;
  localparam logic [3:0] E_SP_OUT_OF_RANGE       = 4'd14;
  localparam logic [3:0] NO_E                    = 4'd15;

  localparam logic [1:0] USER    = 2'b00;
  localparam logic [1:0] MACHINE = 2'b11;

  localparam logic [W-1:0] TEXT_BASE = W'(32'h0008_0000);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_ENTRY   = 3'd1,
    S_HANDLER = 3'd2,
    S_RETURN  = 3'd3,
    S_LOCKUP  = 3'd4
  } state_t;

  // Codes whose mtval is the faulting effective address.
  function automatic logic is_addr_code(input logic [3:0] code);
    case (code)
      E_LOAD_ADDR_MISALIGNED,
      E_LOAD_ACCESS_FAULT,
      E_STORE_ADDR_MISALIGNED,
      E_STORE_ADDR_FAULT,
      E_SP_OUT_OF_RANGE:       is_addr_code = 1'b1;
      default:                 is_addr_code = 1'b0;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [1:0]     priv_q, priv_d;
  logic [1:0]     mpp_q, mpp_d;
  logic [W-1:0]   mepc_q, mepc_d;
  logic [W-1:0]   mcause_q, mcause_d;
  logic [W-1:0]   mtval_q, mtval_d;
  logic           redirect_en_q, redirect_en_d;
  logic [W-1:0]   redirect_pc_q, redirect_pc_d;
  logic           flush_q, flush_d;
  logic           in_trap_q, in_trap_d;
  logic           halt_q, halt_d;

  logic           e_event_s;
  logic           f_event_s;
  logic           mret_s;

  // Qualify the raw stage codes into effective events (E beats F; a taken
  // branch squashes the fetch-stage instruction).
  always_comb begin
    e_event_s = i_valid_e && (i_exception_code_e != NO_E);
    f_event_s = (i_exception_code_f != NO_E) && !e_event_s && !i_branch_taken_e;
    mret_s    = i_valid_e && i_mret_e;
  end

  // Next-state, CSR update and registered-output computation.
  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    mpp_d         = mpp_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_en_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;

    case (state_q)
      S_RUN: begin
        if (e_event_s) begin
          mepc_d        = i_pc_e;
          mcause_d      = {{(W-4){1'b0}}, i_exception_code_e};
          mtval_d       = is_addr_code(i_exception_code_e) ? i_alu_out_e : {W{1'b0}};
          mpp_d         = priv_q;
          priv_d        = MACHINE;
          state_d       = S_ENTRY;
          redirect_en_d = 1'b1;
          redirect_pc_d = i_mtvec;
          flush_d       = 1'b1;
        end else if (f_event_s) begin
          mepc_d        = i_pc_f;
          mcause_d      = {{(W-4){1'b0}}, i_exception_code_f};
          mtval_d       = i_pc_f;
          mpp_d         = priv_q;
          priv_d        = MACHINE;
          state_d       = S_ENTRY;
          redirect_en_d = 1'b1;
          redirect_pc_d = i_mtvec;
          flush_d       = 1'b1;
        end else if (mret_s) begin
          if (priv_q == MACHINE) begin
            // Privilege restore is committed with the redirect so both
            // become visible in the RETURN cycle.
            priv_d        = mpp_q;
            mpp_d         = USER;
            state_d       = S_RETURN;
            redirect_en_d = 1'b1;
            redirect_pc_d = mepc_q;
            flush_d       = 1'b1;
          end else begin
            mepc_d        = i_pc_e;
            mcause_d      = {{(W-4){1'b0}}, E_ILLEGAL_INSTR};
            mtval_d       = {W{1'b0}};
            mpp_d         = priv_q;
            priv_d        = MACHINE;
            state_d       = S_ENTRY;
            redirect_en_d = 1'b1;
            redirect_pc_d = i_mtvec;
            flush_d       = 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_ENTRY: begin
        // Instruction in flight is being flushed; inputs are ignored.
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (e_event_s || f_event_s) begin
          state_d = S_LOCKUP;
        end else if (mret_s) begin
          priv_d        = mpp_q;
          mpp_d         = USER;
          state_d       = S_RETURN;
          redirect_en_d = 1'b1;
          redirect_pc_d = mepc_q;
          flush_d       = 1'b1;
        end else begin
          state_d = S_HANDLER;
        end
      end
      S_RETURN: begin
        state_d = S_RUN;
      end
      S_LOCKUP: begin
        state_d = S_LOCKUP;
      end
      default: begin
        state_d = S_LOCKUP;
      end
    endcase

    in_trap_d = (state_d == S_ENTRY) || (state_d == S_HANDLER);
    halt_d    = (state_d == S_LOCKUP);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_RUN;
      priv_q        <= MACHINE;
      mpp_q         <= USER;
      mepc_q        <= TEXT_BASE;
      mcause_q      <= {W{1'b0}};
      mtval_q       <= {W{1'b0}};
      redirect_en_q <= 1'b0;
      redirect_pc_q <= {W{1'b0}};
      flush_q       <= 1'b0;
      in_trap_q     <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      priv_q        <= priv_d;
      mpp_q         <= mpp_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_en_q <= redirect_en_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      in_trap_q     <= in_trap_d;
      halt_q        <= halt_d;
    end
  end

  assign o_redirect_en       = redirect_en_q;
  assign o_redirect_pc       = redirect_pc_q;
  assign o_flush_fde         = flush_q;
  assign o_current_privilege = priv_q;
  assign o_mepc              = mepc_q;
  assign o_mcause            = mcause_q;
  assign o_mtval             = mtval_q;
  assign o_in_trap           = in_trap_q;
  assign o_halt              = halt_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller (64-bit configuration).
module tb_trap_controller;

  localparam logic [3:0] E_ILLEGAL_INSTR        = 4'd2;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED = 4'd4;
  localparam logic [3:0] E_STORE_ADDR_FAULT     = 4'd7;
  localparam logic [3:0] E_ECALL                = 4'd8;
  localparam logic [3:0] NO_E                   = 4'd15;
  localparam logic [1:0] USER    = 2'b00;
  localparam logic [1:0] MACHINE = 2'b11;

  typedef struct {
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        flush;
    logic [1:0]  priv;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic        in_trap;
    logic        halt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  code_f, code_e;
  logic [63:0] pc_f, pc_e, alu_out, mtvec;
  logic        valid_e, mret_e, br_taken;
  logic        redirect_en, flush, in_trap, halt;
  logic [63:0] redirect_pc, mepc, mcause, mtval;
  logic [1:0]  priv;

  exp_t exp_q[$];
  exp_t cur;
  exp_t reset_exp;
  int   n_vec  = 0;
  int   n_miss = 0;

  trap_controller dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_exception_code_f  (code_f),
    .i_pc_f              (pc_f),
    .i_valid_e           (valid_e),
    .i_exception_code_e  (code_e),
    .i_pc_e              (pc_e),
    .i_alu_out_e         (alu_out),
    .i_mret_e            (mret_e),
    .i_branch_taken_e    (br_taken),
    .i_mtvec             (mtvec),
    .o_redirect_en       (redirect_en),
    .o_redirect_pc       (redirect_pc),
    .o_flush_fde         (flush),
    .o_current_privilege (priv),
    .o_mepc              (mepc),
    .o_mcause            (mcause),
    .o_mtval             (mtval),
    .o_in_trap           (in_trap),
    .o_halt              (halt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic idle();
    code_f = NO_E; code_e = NO_E; valid_e = 1'b0; mret_e = 1'b0; br_taken = 1'b0;
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic cyc(input string tag);
    exp_t e;
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".redirect_en"}, {63'd0, redirect_en}, {63'd0, e.redirect_en});
    check_val({tag, ".redirect_pc"}, redirect_pc, e.redirect_pc);
    check_val({tag, ".flush"},       {63'd0, flush},       {63'd0, e.flush});
    check_val({tag, ".priv"},        {62'd0, priv},        {62'd0, e.priv});
    check_val({tag, ".mepc"},        mepc,   e.mepc);
    check_val({tag, ".mcause"},      mcause, e.mcause);
    check_val({tag, ".mtval"},       mtval,  e.mtval);
    check_val({tag, ".in_trap"},     {63'd0, in_trap},     {63'd0, e.in_trap});
    check_val({tag, ".halt"},        {63'd0, halt},        {63'd0, e.halt});
  endtask

  initial begin
    reset_exp = '{redirect_en: 1'b0, redirect_pc: 64'd0, flush: 1'b0, priv: MACHINE,
                  mepc: 64'h0008_0000, mcause: 64'd0, mtval: 64'd0,
                  in_trap: 1'b0, halt: 1'b0};
    idle();
    pc_f = 64'd0; pc_e = 64'd0; alu_out = 64'd0; mtvec = 64'd0;
    rst = 1'b1;
    #1;
    cur = reset_exp;
    cyc("reset0");
    cyc("reset1");
    rst = 1'b0;
    cyc("idle");

    // Exception code with an invalid (bubble) E slot is not an event.
    code_e = E_ECALL; pc_e = 64'h0000_7000;
    cyc("bubble_no_trap");
    idle();

    // mret from reset code enters user text.
    valid_e = 1'b1; mret_e = 1'b1; pc_e = 64'h0004_0010;
    cur.redirect_en = 1'b1; cur.redirect_pc = 64'h0008_0000; cur.flush = 1'b1; cur.priv = USER;
    cyc("reset_mret");
    idle();
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("return_cycle");
    cyc("run_user");

    // USER load misaligned in E.
    valid_e = 1'b1; code_e = E_LOAD_ADDR_MISALIGNED;
    pc_e = 64'h0008_0020; alu_out = 64'h0010_0003; mtvec = 64'h0;
    cur = '{redirect_en: 1'b1, redirect_pc: 64'h0, flush: 1'b1, priv: MACHINE,
            mepc: 64'h0008_0020, mcause: 64'd4, mtval: 64'h0010_0003,
            in_trap: 1'b1, halt: 1'b0};
    cyc("ld_misal_entry");
    idle();
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("ld_misal_handler");

    // mret from handler returns to mepc in USER.
    valid_e = 1'b1; mret_e = 1'b1;
    cur.redirect_en = 1'b1; cur.redirect_pc = 64'h0008_0020; cur.flush = 1'b1;
    cur.priv = USER; cur.in_trap = 1'b0;
    cyc("handler_mret");
    idle();
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("handler_ret_cycle");
    cyc("back_in_run");

    // Simultaneous F illegal and E ecall: E wins, mtval 0.
    mtvec = 64'h0000_0100;
    code_f = E_ILLEGAL_INSTR; pc_f = 64'h0000_1000;
    valid_e = 1'b1; code_e = E_ECALL; pc_e = 64'h0000_2000; alu_out = 64'h55;
    cur = '{redirect_en: 1'b1, redirect_pc: 64'h100, flush: 1'b1, priv: MACHINE,
            mepc: 64'h2000, mcause: 64'd8, mtval: 64'd0, in_trap: 1'b1, halt: 1'b0};
    cyc("e_beats_f");
    idle();
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("e_beats_f_handler");
    valid_e = 1'b1; mret_e = 1'b1;
    cur.redirect_en = 1'b1; cur.redirect_pc = 64'h2000; cur.flush = 1'b1;
    cur.priv = USER; cur.in_trap = 1'b0;
    cyc("ecall_mret");
    idle();
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("ecall_ret_cycle");

    // F code squashed by taken branch: no trap.
    code_f = E_ILLEGAL_INSTR; pc_f = 64'h0000_1000; br_taken = 1'b1;
    cyc("f_squashed");
    idle();

    // F-only trap: mtval = pc_f.
    code_f = E_ILLEGAL_INSTR; pc_f = 64'h0000_3000;
    cur = '{redirect_en: 1'b1, redirect_pc: 64'h100, flush: 1'b1, priv: MACHINE,
            mepc: 64'h3000, mcause: 64'd2, mtval: 64'h3000, in_trap: 1'b1, halt: 1'b0};
    cyc("f_trap");
    idle();
    // Event during ENTRY is dropped: no lockup.
    valid_e = 1'b1; code_e = E_STORE_ADDR_FAULT; pc_e = 64'h0000_9999;
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("entry_drops_event");
    idle();
    cyc("f_trap_handler");

    // Nested trap in HANDLER: lockup, CSRs unchanged, sticky.
    valid_e = 1'b1; code_e = E_STORE_ADDR_FAULT; pc_e = 64'h0000_9999; alu_out = 64'h1234;
    cur.halt = 1'b1; cur.in_trap = 1'b0;
    cyc("nested_lockup");
    idle();
    for (int i = 0; i < 12; i++) begin
      valid_e = 1'b1; mret_e = (i % 2 == 0);
      code_f = (i % 3 == 0) ? E_ILLEGAL_INSTR : NO_E;
      cyc("lockup_hold");
    end
    idle();

    rst = 1'b1;
    cur = reset_exp;
    cyc("rst_from_lockup");
    rst = 1'b0;
    cyc("after_rst");

    // Enter USER, then USER mret traps as illegal instruction.
    valid_e = 1'b1; mret_e = 1'b1; pc_e = 64'h0004_0010;
    cur.redirect_en = 1'b1; cur.redirect_pc = 64'h0008_0000; cur.flush = 1'b1; cur.priv = USER;
    cyc("reset_mret2");
    idle();
    cur.redirect_en = 1'b0; cur.flush = 1'b0;
    cyc("return_cycle2");
    valid_e = 1'b1; mret_e = 1'b1; pc_e = 64'h0008_0040;
    cur = '{redirect_en: 1'b1, redirect_pc: 64'h100, flush: 1'b1, priv: MACHINE,
            mepc: 64'h0008_0040, mcause: 64'd2, mtval: 64'd0, in_trap: 1'b1, halt: 1'b0};
    cyc("user_mret_illegal");
    idle();

    // Reset during ENTRY wins.
    rst = 1'b1;
    cur = reset_exp;
    cyc("rst_in_entry");
    rst = 1'b0;
    cyc("after_rst_entry");
    cyc("after_rst_entry2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
